// File: rtl/keyrupt_sequencer_pkg.sv
// Shared types and helpers for the keyrupt sequencer and its channels.
package keyrupt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Width of the per-channel pulse-width counter; PULSE_W fits in 1..15.
  localparam int PW_W = 4;

  // Upper bounds for the generic slice helper below.
  localparam int MAX_BUS_W = 512;
  localparam int MAX_CNT_W = 32;

  // Extract channel idx from a flattened cfg bus of cnt_w-bit fields.
  // The caller truncates the result to its own field width.
  function automatic logic [MAX_CNT_W-1:0] cfg_slice(input logic [MAX_BUS_W-1:0] bus,
                                                     input int idx,
                                                     input int cnt_w);
    return MAX_CNT_W'(bus >> (idx * cnt_w));
  endfunction

endpackage

// File: rtl/keyrupt_sequencer_if.sv
// Bus between the keyrupt sequencer and whatever drives/observes it.
// master = bench or FPGA wrapper, slave = the sequencer itself.
interface keyrupt_sequencer_if #(
  parameter int CHANNELS = 3,
  parameter int CNT_W    = 14
);
  logic                      booted;
  logic [CHANNELS*CNT_W-1:0] trig_cfg;
  logic [CHANNELS*CNT_W-1:0] period_cfg;
  logic [CHANNELS-1:0]       ch_en;
  logic [CHANNELS-1:0]       irq;
  logic                      boot_seen;
  logic                      run_active;
  logic                      done;
  logic [CNT_W-1:0]          cycles_left;

  modport master (
    output booted, trig_cfg, period_cfg, ch_en,
    input  irq, boot_seen, run_active, done, cycles_left
  );

  modport slave (
    input  booted, trig_cfg, period_cfg, ch_en,
    output irq, boot_seen, run_active, done, cycles_left
  );
endinterface

// File: rtl/keyrupt_sequencer_channel.sv
// One interrupt channel: first fire on a countdown match, optional periodic
// re-fire, and a width counter that stretches each fire into a pulse.
module keyrupt_channel
  import keyrupt_pkg::*;
#(
  parameter int CNT_W   = 14,
  parameter int PULSE_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             run_next,
  input  logic [CNT_W-1:0] cycles_left,
  input  logic [CNT_W-1:0] trig,
  input  logic [CNT_W-1:0] period,
  input  logic             en,
  output logic             irq
);

  localparam logic [PW_W-1:0]  PW_LOAD = PW_W'(PULSE_W);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PW_W-1:0]  PW_ONE  = PW_W'(1);

  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [PW_W-1:0]  wcnt_q, wcnt_d;
  logic             irq_q, irq_d;
  logic             first_hit;
  logic             period_hit;
  logic             fire;

  // Channel registers; everything returns to zero on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q <= '0;
      wcnt_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      wcnt_q <= wcnt_d;
      irq_q  <= irq_d;
    end
  end

  // Fire decision, period countdown (frozen while disabled) and pulse
  // stretching; a re-fire restarts the width counter so pulses merge.
  // Leaving RUN wipes the channel so irq drops on the very next cycle.
  always_comb begin
    first_hit  = (trig != '0) && (cycles_left == trig);
    period_hit = (pcnt_q == CNT_ONE);
    fire       = run & en & (first_hit | period_hit);
    pcnt_d     = pcnt_q;
    wcnt_d     = wcnt_q;
    if (fire) begin
      pcnt_d = period;
    end else if (run && en && (pcnt_q != '0)) begin
      pcnt_d = pcnt_q - CNT_ONE;
    end
    if (fire) begin
      wcnt_d = PW_LOAD;
    end else if (wcnt_q != '0) begin
      wcnt_d = wcnt_q - PW_ONE;
    end
    if (!run_next) begin
      pcnt_d = '0;
      wcnt_d = '0;
    end
    irq_d = (wcnt_d != '0);
  end

  assign irq = irq_q;

endmodule

// File: rtl/keyrupt_sequencer.sv
// Post-boot run-window sequencer: detects the boot edge, runs a fixed
// countdown, drives per-channel keyrupt lines and flags completion.
module keyrupt_sequencer
  import keyrupt_pkg::*;
#(
  parameter int CHANNELS   = 3,
  parameter int CNT_W      = 14,
  parameter int RUN_CYCLES = 8192,
  parameter int PULSE_W    = 1
) (
  input  logic            clk,
  input  logic            rst,
  keyrupt_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] RUN_LOAD = CNT_W'(RUN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic             booted_q, booted_d;
  logic             boot_armed_q, boot_armed_d;
  logic             boot_seen_q, boot_seen_d;
  logic [CNT_W-1:0] cycles_left_q, cycles_left_d;
  logic             boot_edge;
  logic             run_now;
  logic             run_next;
  logic [CHANNELS-1:0] irq_vec;

  // State register and status flops, all cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      booted_q      <= 1'b0;
      boot_armed_q  <= 1'b0;
      boot_seen_q   <= 1'b0;
      cycles_left_q <= '0;
    end else begin
      state_q       <= state_d;
      booted_q      <= booted_d;
      boot_armed_q  <= boot_armed_d;
      boot_seen_q   <= boot_seen_d;
      cycles_left_q <= cycles_left_d;
    end
  end

  // Boot edge detect and IDLE/RUN/DONE sequencing. A boot edge only counts
  // once booted has been seen low since reset, so a level that is still high
  // when reset releases does not start a run. Abort takes priority over the
  // final countdown step.
  always_comb begin
    booted_d      = bus.booted;
    boot_armed_d  = boot_armed_q | ~bus.booted;
    boot_edge     = bus.booted & ~booted_q & boot_armed_q;
    state_d       = state_q;
    cycles_left_d = cycles_left_q;
    boot_seen_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (boot_edge) begin
          state_d       = ST_RUN;
          cycles_left_d = RUN_LOAD;
          boot_seen_d   = 1'b1;
        end
      end
      ST_RUN: begin
        if (!bus.booted) begin
          state_d       = ST_IDLE;
          cycles_left_d = '0;
        end else if (cycles_left_q == CNT_ONE) begin
          state_d       = ST_DONE;
          cycles_left_d = '0;
        end else begin
          cycles_left_d = cycles_left_q - CNT_ONE;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d       = ST_IDLE;
        cycles_left_d = '0;
      end
    endcase
  end

  assign run_now  = (state_q == ST_RUN);
  assign run_next = (state_d == ST_RUN);

  // One channel instance per interrupt line.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [CNT_W-1:0] trig_sel;
    logic [CNT_W-1:0] period_sel;

    assign trig_sel   = CNT_W'(cfg_slice(MAX_BUS_W'(bus.trig_cfg), gi, CNT_W));
    assign period_sel = CNT_W'(cfg_slice(MAX_BUS_W'(bus.period_cfg), gi, CNT_W));

    keyrupt_channel #(
      .CNT_W   (CNT_W),
      .PULSE_W (PULSE_W)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .run         (run_now),
      .run_next    (run_next),
      .cycles_left (cycles_left_q),
      .trig        (trig_sel),
      .period      (period_sel),
      .en          (bus.ch_en[gi]),
      .irq         (irq_vec[gi])
    );
  end

  assign bus.irq         = irq_vec;
  assign bus.boot_seen   = boot_seen_q;
  assign bus.run_active  = run_now;
  assign bus.done        = (state_q == ST_DONE);
  assign bus.cycles_left = cycles_left_q;

endmodule

// File: tb/tb_keyrupt_sequencer.sv
// Self-checking bench for keyrupt_sequencer: a PULSE_W=1 and a PULSE_W=4
// instance share one stimulus and are checked every cycle against a
// behavioural model, plus literal timing expectations per scenario.
module tb_keyrupt_sequencer;

  localparam int CH  = 3;
  localparam int CW  = 14;
  localparam int RC  = 8192;
  localparam int NONE = -100000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic booted = 1'b0;
  logic [CH*CW-1:0] trig_cfg = '0;
  logic [CH*CW-1:0] period_cfg = '0;
  logic [CH-1:0] ch_en = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int ncyc = 0;
  bit chk_on = 1'b0;

  keyrupt_sequencer_if #(.CHANNELS(CH), .CNT_W(CW)) if1 ();
  keyrupt_sequencer_if #(.CHANNELS(CH), .CNT_W(CW)) if4 ();

  assign if1.booted = booted;
  assign if1.trig_cfg = trig_cfg;
  assign if1.period_cfg = period_cfg;
  assign if1.ch_en = ch_en;
  assign if4.booted = booted;
  assign if4.trig_cfg = trig_cfg;
  assign if4.period_cfg = period_cfg;
  assign if4.ch_en = ch_en;

  keyrupt_sequencer #(.CHANNELS(CH), .CNT_W(CW), .RUN_CYCLES(RC), .PULSE_W(1)) dut (
    .clk (clk), .rst (rst), .bus (if1)
  );

  keyrupt_sequencer #(.CHANNELS(CH), .CNT_W(CW), .RUN_CYCLES(RC), .PULSE_W(4)) dut_w4 (
    .clk (clk), .rst (rst), .bus (if4)
  );

  always #5 clk = ~clk;

  // Every comparison goes through here so the counters stay in one place.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, ncyc, act, exp);
    end
  endtask

  // Behavioural model. Phase 0/1/2 = idle/run/done. A channel's irq is high
  // in cycle c when we are in RUN and its latest fire happened 1..PW cycles
  // earlier. Periodic re-fire happens after period-1 enabled RUN cycles have
  // elapsed since the previous fire.
  int m_phase = 0;
  int m_left = 0;
  bit m_seen = 1'b0;
  bit m_bprev = 1'b0;
  bit m_lowseen = 1'b0;
  int m_last [CH];
  bit m_armed [CH];
  int m_per [CH];
  int m_elapsed [CH];

  always @(posedge clk) begin
    int trg, per, cur;
    bit edge_b, hit;
    cur = ncyc;
    if (rst) begin
      m_phase = 0; m_left = 0; m_seen = 0; m_bprev = 0; m_lowseen = 0;
      for (int i = 0; i < CH; i++) begin
        m_last[i] = NONE; m_armed[i] = 0; m_per[i] = 0; m_elapsed[i] = 0;
      end
    end else begin
      edge_b = booted && !m_bprev && m_lowseen;
      if (m_phase == 1) begin
        for (int i = 0; i < CH; i++) begin
          if (ch_en[i]) begin
            trg = int'(trig_cfg[i*CW +: CW]);
            per = int'(period_cfg[i*CW +: CW]);
            hit = (trg == m_left) || (m_armed[i] && (m_elapsed[i] == m_per[i] - 1));
            if (hit) begin
              m_last[i] = cur;
              m_armed[i] = (per != 0);
              m_per[i] = per;
              m_elapsed[i] = 0;
            end else if (m_armed[i]) begin
              m_elapsed[i]++;
            end
          end
        end
      end
      m_seen = (m_phase == 0) && edge_b;
      if (m_phase == 0 && edge_b) begin
        m_phase = 1; m_left = RC;
      end else if (m_phase == 1) begin
        if (!booted || m_left == 1) begin
          m_phase = booted ? 2 : 0;
          m_left = 0;
          for (int i = 0; i < CH; i++) begin
            m_last[i] = NONE; m_armed[i] = 0;
          end
        end else begin
          m_left--;
        end
      end
      m_bprev = booted;
      if (!booted) m_lowseen = 1;
    end
    ncyc = cur + 1;
  end

  function automatic logic [CH-1:0] expIrq(input int pw);
    logic [CH-1:0] v;
    v = '0;
    for (int i = 0; i < CH; i++)
      v[i] = (m_phase == 1) && (ncyc - m_last[i] >= 1) && (ncyc - m_last[i] <= pw);
    return v;
  endfunction

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      checkOutput("boot_seen", 32'(if1.boot_seen), 32'(m_seen));
      checkOutput("run_active", 32'(if1.run_active), 32'(m_phase == 1));
      checkOutput("done", 32'(if1.done), 32'(m_phase == 2));
      checkOutput("cycles_left", 32'(if1.cycles_left), 32'(m_left));
      checkOutput("irq_pw1", 32'(if1.irq), 32'(expIrq(1)));
      checkOutput("w4_boot_seen", 32'(if4.boot_seen), 32'(m_seen));
      checkOutput("w4_run_active", 32'(if4.run_active), 32'(m_phase == 1));
      checkOutput("w4_done", 32'(if4.done), 32'(m_phase == 2));
      checkOutput("w4_cycles_left", 32'(if4.cycles_left), 32'(m_left));
      checkOutput("irq_pw4", 32'(if4.irq), 32'(expIrq(4)));
    end
  end

  // Event recorder used by the literal timing checks.
  int rise1 [CH];
  int first1 [CH];
  int high1 [CH];
  int rise4 [CH];
  int high4 [CH];
  int last4 [CH];
  int bs_cnt, bs_first, done_rise;
  logic [CH-1:0] prev1 = '0;
  logic [CH-1:0] prev4 = '0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    for (int i = 0; i < CH; i++) begin
      if (if1.irq[i] === 1'b1 && prev1[i] !== 1'b1) begin
        rise1[i]++;
        if (first1[i] < 0) first1[i] = ncyc;
      end
      if (if1.irq[i] === 1'b1) high1[i]++;
      if (if4.irq[i] === 1'b1 && prev4[i] !== 1'b1) rise4[i]++;
      if (if4.irq[i] === 1'b1) begin
        high4[i]++;
        last4[i] = ncyc;
      end
    end
    prev1 = if1.irq;
    prev4 = if4.irq;
    if (if1.boot_seen === 1'b1) begin
      bs_cnt++;
      if (bs_first < 0) bs_first = ncyc;
    end
    if (if1.done === 1'b1 && prev_done !== 1'b1 && done_rise < 0) done_rise = ncyc;
    prev_done = if1.done;
  end

  task automatic clearMon();
    for (int i = 0; i < CH; i++) begin
      rise1[i] = 0; first1[i] = -1; high1[i] = 0;
      rise4[i] = 0; high4[i] = 0; last4[i] = -1;
    end
    bs_cnt = 0; bs_first = -1; done_rise = -1;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int t0, input int p0, input int t1, input int p1,
                               input int t2, input int p2, input logic [CH-1:0] en);
    logic [CW-1:0] a0, a1, a2, b0, b1, b2;
    a0 = CW'(t0); a1 = CW'(t1); a2 = CW'(t2);
    b0 = CW'(p0); b1 = CW'(p1); b2 = CW'(p2);
    trig_cfg = {a2, a1, a0};
    period_cfg = {b2, b1, b0};
    ch_en = en;
  endtask

  task automatic doReset();
    booted = 1'b0;
    rst = 1'b1;
    waitCycles(2);
    rst = 1'b0;
    waitCycles(2);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_irq"}, 32'(if1.irq), 0);
    checkOutput({tag, "_boot_seen"}, 32'(if1.boot_seen), 0);
    checkOutput({tag, "_run_active"}, 32'(if1.run_active), 0);
    checkOutput({tag, "_done"}, 32'(if1.done), 0);
    checkOutput({tag, "_cycles_left"}, 32'(if1.cycles_left), 0);
  endtask

  initial begin
    int t, t2;
    clearMon();
    waitCycles(1);
    chk_on = 1'b1;
    waitCycles(2);
    checkAllZero("reset");
    rst = 1'b0;
    waitCycles(2);

    // Legacy one-shot pattern, then a boot edge during DONE that must be ignored.
    applyStimulus(4096, 0, 2048, 0, 1024, 0, 3'b111);
    clearMon();
    booted = 1'b1;
    t = ncyc;
    waitCycles(8200);
    checkOutput("legacy_boot_seen_at", 32'(bs_first), 32'(t + 1));
    checkOutput("legacy_irq0_at", 32'(first1[0]), 32'(t + 4098));
    checkOutput("legacy_irq1_at", 32'(first1[1]), 32'(t + 6146));
    checkOutput("legacy_irq2_at", 32'(first1[2]), 32'(t + 7170));
    for (int i = 0; i < CH; i++) checkOutput("legacy_irq_width", 32'(high1[i]), 1);
    checkOutput("legacy_done_at", 32'(done_rise), 32'(t + 8193));
    booted = 1'b0;
    waitCycles(3);
    booted = 1'b1;
    waitCycles(5);
    checkOutput("done_sticky", 32'(if1.done), 1);
    checkOutput("done_ignores_boot", 32'(bs_cnt), 1);

    // Periodic channel, trig=0 channel, and trig=RUN_CYCLES channel.
    doReset();
    applyStimulus(100, 50, 0, 5, 8192, 0, 3'b111);
    clearMon();
    booted = 1'b1;
    t = ncyc;
    waitCycles(8200);
    checkOutput("periodic_count", 32'(rise1[0]), 2);
    checkOutput("periodic_first_at", 32'(first1[0]), 32'(t + 8094));
    checkOutput("trig0_count", 32'(rise1[1]), 0);
    checkOutput("trig_max_at", 32'(first1[2]), 32'(t + 2));
    checkOutput("trig_max_count", 32'(rise1[2]), 1);
    checkOutput("irq_after_done", 32'(if1.irq), 0);

    // Abort mid-run, then a fresh full run.
    doReset();
    applyStimulus(9000, 3, 8190, 0, 8000, 100, 3'b111);
    clearMon();
    booted = 1'b1;
    t = ncyc;
    waitCycles(3000);
    booted = 1'b0;
    waitCycles(1);
    checkOutput("abort_run_active", 32'(if1.run_active), 0);
    checkOutput("abort_done", 32'(if1.done), 0);
    checkOutput("abort_irq", 32'(if1.irq), 0);
    waitCycles(9);
    booted = 1'b1;
    t2 = ncyc;
    waitCycles(8200);
    checkOutput("rerun_boot_seen", 32'(bs_cnt), 2);
    checkOutput("trig_over_count", 32'(rise1[0]), 0);
    checkOutput("rerun_ch1_count", 32'(rise1[1]), 2);
    checkOutput("rerun_ch2_count", 32'(rise1[2]), 109);
    checkOutput("rerun_done_at", 32'(done_rise), 32'(t2 + 8193));

    // Pulse merging on the PULSE_W=4 instance, with ch_en0 dropped late.
    doReset();
    applyStimulus(10, 2, 10, 2, 1, 0, 3'b111);
    clearMon();
    booted = 1'b1;
    t = ncyc;
    waitCycles(8186);
    ch_en = 3'b110;
    waitCycles(14);
    checkOutput("merge_ch0_rises", 32'(rise4[0]), 1);
    checkOutput("merge_ch0_high", 32'(high4[0]), 6);
    checkOutput("merge_ch0_last", 32'(last4[0]), 32'(t + 8189));
    checkOutput("merge_ch1_rises", 32'(rise4[1]), 1);
    checkOutput("merge_ch1_high", 32'(high4[1]), 9);
    checkOutput("merge_ch1_last", 32'(last4[1]), 32'(t + 8192));
    checkOutput("last_cycle_fire", 32'(rise4[2]), 0);
    checkOutput("pw1_ch0_rises", 32'(rise1[0]), 2);

    // Reset mid-run with booted held high.
    doReset();
    applyStimulus(8000, 0, 0, 0, 0, 0, 3'b111);
    booted = 1'b1;
    waitCycles(500);
    rst = 1'b1;
    waitCycles(1);
    rst = 1'b0;
    checkAllZero("midrst");
    waitCycles(20);
    checkOutput("no_run_while_high", 32'(if1.run_active), 0);
    booted = 1'b0;
    waitCycles(3);
    booted = 1'b1;
    waitCycles(1);
    checkOutput("rearm_boot_seen", 32'(if1.boot_seen), 1);
    checkOutput("rearm_cycles_left", 32'(if1.cycles_left), 8192);
    waitCycles(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
